// File: rtl/ififo_pkg.sv
// ---------------------------------------------------------------------------
// ififo_pkg
//   Shared constants for the 64x85 BRAM-backed input FIFO controller:
//   default RAM depth, address width, flit width, almost-full threshold,
//   and the width of the total-occupancy count.
// ---------------------------------------------------------------------------
package ififo_pkg;
    localparam int FIFO_DEPTH = 64;             // RAM entries, power of 2
    localparam int FIFO_AW    = 6;              // log2(FIFO_DEPTH)
    localparam int FIFO_DW    = 85;             // flit width
    localparam int FIFO_AFULL = 56;             // almost_full threshold
    localparam int FIFO_CW    = FIFO_AW + 1;    // count width, holds 0..DEPTH+2
endpackage

// File: rtl/ififo_skid2.sv
// ---------------------------------------------------------------------------
// ififo_skid2
//   Two-entry output skid buffer. Entry 0 is always the head. A pop shifts
//   entry 1 down; a push lands in the first free slot after any pop.
//   Push and pop in the same cycle are legal at any occupancy the caller
//   allows (caller never pushes into a full buffer without popping).
//
// Ports
//   clk        in   clock, posedge
//   reset      in   synchronous, active-high; clears occupancy only
//   push       in   write push_data this cycle
//   push_data  in   DW  flit to store
//   pop        in   remove head this cycle
//   occ        out  2   occupancy 0..2
//   head_data  out  DW  current head (don't-care when occ == 0)
// ---------------------------------------------------------------------------
module ififo_skid2
    import ififo_pkg::*;
#(
    parameter int DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic [DW-1:0] head_data
);

    logic [1:0]    occ_d, occ_q;
    logic [DW-1:0] e0_d, e0_q;
    logic [DW-1:0] e1_d, e1_q;
    logic [1:0]    slot;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        occ_d = occ_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        slot  = occ_q - {1'b0, pop};

        if (pop) begin
            e0_d = e1_q;
        end
        if (push) begin
            if (slot == 2'd0) begin
                e0_d = push_data;
            end else begin
                e1_d = push_data;
            end
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // NOTE: data registers carry no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        e0_q <= e0_d;
        e1_q <= e1_d;
    end

    assign occ       = occ_q;
    assign head_data = e0_q;

endmodule

// File: rtl/ififo_ctl_64x85.sv
// ---------------------------------------------------------------------------
// ififo_ctl_64x85
//   Valid/ready FIFO controller wrapped around an external 64x85 1R1W BRAM
//   with a one-cycle registered read. Pushes go to the RAM write port;
//   reads are prefetched whenever the output skid (plus the read in flight)
//   has room, so the consumer sees a 1 flit/cycle valid/ready stream.
//
//   Optional macro IFIFO_BYPASS_EN: when the RAM is empty and no read is in
//   flight, a push is written straight into the skid (1-cycle latency).
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_data flit
//   out_valid/out_ready   downstream handshake, out_data head flit
//   count                 total occupancy (RAM + read in flight + skid)
//   almost_full           count >= AFULL_THRESH
//   ram_ena/ram_wea       RAM write enables (both = RAM write)
//   ram_addra/ram_dia     RAM write address / data
//   ram_enb/ram_addrb     RAM read issue / address
//   ram_dob               RAM read data, valid the cycle after ram_enb
// ---------------------------------------------------------------------------
module ififo_ctl_64x85
    import ififo_pkg::*;
#(
    parameter int DEPTH        = FIFO_DEPTH,
    parameter int AW           = FIFO_AW,
    parameter int DW           = FIFO_DW,
    parameter int AFULL_THRESH = FIFO_AFULL
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   count,
    output logic          almost_full,
    output logic          ram_ena,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dia,
    output logic          ram_enb,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_dob
);

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AFULL_C = AFULL_THRESH[AW:0];

    logic [AW:0]   wptr_d, wptr_q;
    logic [AW:0]   rptr_d, rptr_q;
    logic          rd_v_d, rd_v_q;
    logic [AW:0]   ram_cnt;
    logic [AW:0]   total;
    logic [2:0]    pend;
    logic          push, pop, rd_issue, bypass, ram_push, skid_push;
    logic [1:0]    occ;
    logic [DW-1:0] skid_head, skid_wdata;

    always_comb begin
        // Wrap bit makes full (address equal, wrap differs) read as DEPTH.
        ram_cnt   = wptr_q - rptr_q;
        in_ready  = !reset && (ram_cnt < DEPTH_C);
        out_valid = !reset && (occ != 2'd0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;

        // Skid slots already claimed after this cycle's pop; a pop only
        // happens with occ >= 1, so the subtraction never underflows.
        pend      = {1'b0, occ} + {2'b0, rd_v_q} - {2'b0, pop};
        rd_issue  = !reset && (ram_cnt != '0) && (pend < 3'd2);

`ifdef IFIFO_BYPASS_EN
        // Empty RAM and nothing in flight: the skid holds the whole queue,
        // so writing in_data there directly keeps ordering.
        bypass     = push && (ram_cnt == '0) && !rd_v_q
                     && (({1'b0, occ} - {2'b0, pop}) < 3'd2);
        skid_wdata = rd_v_q ? ram_dob : in_data;
`else
        bypass     = 1'b0;
        skid_wdata = ram_dob;
`endif
        ram_push  = push && !bypass;
        skid_push = rd_v_q || bypass;

        wptr_d = wptr_q + {{AW{1'b0}}, ram_push};
        rptr_d = rptr_q + {{AW{1'b0}}, rd_issue};
        rd_v_d = rd_issue;

        total       = ram_cnt + {{AW{1'b0}}, rd_v_q} + {{(AW-1){1'b0}}, occ};
        count       = reset ? '0 : total;
        almost_full = !reset && (total >= AFULL_C);

        ram_ena   = ram_push;
        ram_wea   = ram_push;
        ram_addra = wptr_q[AW-1:0];
        ram_dia   = in_data;
        ram_enb   = rd_issue;
        ram_addrb = rptr_q[AW-1:0];
        out_data  = skid_head;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            rd_v_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            rd_v_q <= rd_v_d;
        end
    end

    ififo_skid2 #(.DW(DW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (skid_push),
        .push_data (skid_wdata),
        .pop       (pop),
        .occ       (occ),
        .head_data (skid_head)
    );

endmodule

// File: tb/tb_ififo_ctl_64x85.sv
// ---------------------------------------------------------------------------
// tb_ififo_ctl_64x85
//   Self-checking bench for ififo_ctl_64x85 with a behavioural BRAM model.
//   Reference model: the FIFO contents as a queue of flits, plus the number
//   of flits held in the RAM and in flight, derived from the RAM port
//   traffic. Every cycle the count, flags and head data are compared with
//   what the queue implies.
// ---------------------------------------------------------------------------
module tb_ififo_ctl_64x85;
    import ififo_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;
    localparam int AW    = FIFO_AW;
    localparam int DW    = FIFO_DW;
    localparam int AFULL = FIFO_AFULL;
`ifdef IFIFO_BYPASS_EN
    localparam int EXP_LAT = 0;
`else
    localparam int EXP_LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [AW:0]   count;
    logic          almost_full;
    logic          ram_ena, ram_wea, ram_enb;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dia, ram_dob;

    always #5 clk = ~clk;

    ififo_ctl_64x85 dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full),
        .ram_ena     (ram_ena),
        .ram_wea     (ram_wea),
        .ram_addra   (ram_addra),
        .ram_dia     (ram_dia),
        .ram_enb     (ram_enb),
        .ram_addrb   (ram_addrb),
        .ram_dob     (ram_dob)
    );

    // Behavioural 1R1W BRAM with registered read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_enb) ram_dob <= mem[ram_addrb];
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_flit();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // ---------------- reference model / monitor ----------------
    logic [DW-1:0] q [$];
    int ram_occ  = 0;
    int inflight = 0;
    int wr_a     = 0;
    int rd_a     = 0;

    always @(negedge clk) begin : monitor
        int skid;
        if (reset) begin
            check("rst_in_ready",    in_ready,    1'b0);
            check("rst_out_valid",   out_valid,   1'b0);
            check("rst_count",       count,       0);
            check("rst_almost_full", almost_full, 1'b0);
            check("rst_ram_ena",     ram_ena,     1'b0);
            check("rst_ram_enb",     ram_enb,     1'b0);
            q.delete();
            ram_occ = 0; inflight = 0; wr_a = 0; rd_a = 0;
        end else begin
            skid = q.size() - ram_occ - inflight;
            check("count",       count,       q.size());
            check("almost_full", almost_full, q.size() >= AFULL);
            check("in_ready",    in_ready,    ram_occ < DEPTH);
            check("out_valid",   out_valid,   skid > 0);
            check("skid_range",  (skid >= 0) && (skid <= 2), 1'b1);
            check("ram_wea",     ram_wea,     ram_ena);
            if (ram_ena) begin
                check("ram_addra", ram_addra, wr_a);
                check("ram_dia",   ram_dia,   in_data);
            end
            if (ram_enb) begin
                check("enb_nonempty", ram_occ > 0, 1'b1);
                check("ram_addrb",    ram_addrb,   rd_a);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("pop_empty_model", 1'b1, 1'b0);
                end else begin
                    check("out_data", out_data, q[0]);
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(in_data);
            if (ram_ena && ram_wea) begin
                ram_occ++;
                wr_a = (wr_a + 1) % DEPTH;
            end
            if (ram_enb) begin
                ram_occ--;
                rd_a = (rd_a + 1) % DEPTH;
            end
            inflight = ram_enb ? 1 : 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, sent, cyc, af_at, exp_i, got_n, gaps, stalls;
        logic [DW-1:0] fx, fy;
        logic [DW-1:0] sq [$];
        bit started;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        check("post_reset_count", count, 0);
        check("post_reset_in_ready", in_ready, 1'b1);

        // Single flit latency.
        in_valid = 1'b1; in_data = DW'(85'h1_2345); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin step(); lat++; end
        check("single_latency", lat, EXP_LAT);
        check("single_data", out_data, 85'h1_2345);
        step();
        check("single_count0", count, 0);
        out_ready = 1'b0;

        // Fill with out_ready low.
        sent = 0; cyc = 0; af_at = -1;
        while (sent < 66 && cyc < 500) begin
            in_valid = 1'b1; in_data = DW'(sent);
            #1;
            if (almost_full && af_at < 0) af_at = count;
            if (in_ready) sent++;
            step(); cyc++;
        end
        in_valid = 1'b0;
        repeat (4) begin
            if (almost_full && af_at < 0) af_at = count;
            step();
        end
        check("fill_sent", sent, 66);
        check("fill_count", count, 66);
        check("fill_in_ready", in_ready, 1'b0);
        check("fill_almost_full", almost_full, 1'b1);
        check("afull_first_count", af_at, AFULL);

        // Push attempt + pop at count 66: in_ready independent of out_ready.
        out_ready = 1'b1; in_valid = 1'b1; in_data = DW'(999);
        #1;
        check("full_in_ready_no_glitch", in_ready, 1'b0);
        check("full_head", out_data, 0);
        step();
        in_valid = 1'b0;
        check("full_after_pop_count", count, 65);

        // Drain the rest in order.
        exp_i = 1; cyc = 0;
        while (exp_i < 66 && cyc < 500) begin
            if (out_valid) begin
                check("drain_order", out_data, exp_i);
                exp_i++;
            end
            step(); cyc++;
        end
        check("drain_all", exp_i, 66);
        check("drain_count0", count, 0);
        out_ready = 1'b0;

        // Simultaneous push and pop at count 1.
        fx = rand_flit(); fy = rand_flit();
        in_valid = 1'b1; in_data = fx;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 10) begin step(); cyc++; end
        check("c1_count", count, 1);
        in_valid = 1'b1; in_data = fy; out_ready = 1'b1;
        #1;
        check("c1_in_ready", in_ready, 1'b1);
        check("c1_head", out_data, fx);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("c1_count_unchanged", count, 1);
        cyc = 0;
        while (!out_valid && cyc < 10) begin step(); cyc++; end
        check("c1_second", out_data, fy);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("c1_empty", count, 0);

        // Streaming 200 flits, both sides always ready.
        sent = 0; got_n = 0; cyc = 0; gaps = 0; stalls = 0; started = 0;
        out_ready = 1'b1;
        while ((sent < 200 || got_n < 200) && cyc < 2000) begin
            in_valid = (sent < 200);
            in_data  = rand_flit();
            #1;
            if (in_valid) begin
                if (in_ready) sent++;
                else stalls++;
            end
            if (out_valid) begin
                got_n++;
                started = 1;
            end else if (started) begin
                gaps++;
            end
            step(); cyc++;
        end
        in_valid = 1'b0;
        check("stream_got", got_n, 200);
        check("stream_gaps", gaps, 0);
        check("stream_in_stalls", stalls, 0);
        check("stream_count0", count, 0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 1);
            in_data   = rand_flit();
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (count != 0 && cyc < 200) begin step(); cyc++; end
        check("random_drained", count, 0);
        out_ready = 1'b0;

        // Reset mid-stream at count 30.
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1; in_data = rand_flit();
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        check("pre_reset_count", count, 30);
        reset = 1'b1;
        #1;
        check("mid_reset_count", count, 0);
        check("mid_reset_out_valid", out_valid, 1'b0);
        check("mid_reset_in_ready", in_ready, 1'b0);
        step();
        reset = 1'b0;
        #1;
        check("after_reset_count", count, 0);
        check("after_reset_out_valid", out_valid, 1'b0);
        in_valid = 1'b1; in_data = DW'(8'hAA);
        step();
        in_data = DW'(8'hBB);
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 10) begin step(); cyc++; end
        check("after_reset_first", out_data, 8'hAA);
        cyc = 0;
        while (count != 0 && cyc < 20) begin step(); cyc++; end
        check("after_reset_drained", count, 0);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
